// File: rtl/irrig_pkg.sv
// Shared definitions for the irrigation zone scheduler: default sizing and FSM state encoding.
package irrig_pkg;

    localparam int DEF_N_ZONES = 4;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/irrigation_zone_scheduler_if.sv
// Request/valve bundle between the sensor logic (master) and the zone scheduler (slave).
interface irrigation_zone_scheduler_if
    import irrig_pkg::*;
#(
    parameter int N_ZONES = DEF_N_ZONES,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int ZW = $clog2(N_ZONES);

    logic                     EN;
    logic                     TICK;
    logic [N_ZONES-1:0]       ZONE_REQ;
    logic [N_ZONES*CNT_W-1:0] DUR;
    logic                     ABORT;
    logic [N_ZONES-1:0]       VALVE;
    logic [ZW-1:0]            ACTIVE_ZONE;
    logic [CNT_W-1:0]         REMAIN;
    logic                     BUSY;
    logic                     DONE_P;
    logic [N_ZONES-1:0]       PENDING;

    modport master (
        output EN, TICK, ZONE_REQ, DUR, ABORT,
        input  VALVE, ACTIVE_ZONE, REMAIN, BUSY, DONE_P, PENDING
    );

    modport slave (
        input  EN, TICK, ZONE_REQ, DUR, ABORT,
        output VALVE, ACTIVE_ZONE, REMAIN, BUSY, DONE_P, PENDING
    );

endinterface

// File: rtl/irrig_down_counter.sv
// Shared watering timer: synchronous clear/load, decrement that saturates at zero.
module irrig_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin scheduler sharing one countdown timer among N irrigation zones.
module irrigation_zone_scheduler
    import irrig_pkg::*;
#(
    parameter int N_ZONES = DEF_N_ZONES,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                          CLK,
    input  logic                          RESET,
    irrigation_zone_scheduler_if.slave    zif
);

    localparam int ZW = $clog2(N_ZONES);

    state_t             state, state_n;
    logic [ZW-1:0]      rr_ptr, rr_n;
    logic [ZW-1:0]      active_zone, az_n;
    logic [N_ZONES-1:0] pending, pend_clr;
    logic [N_ZONES-1:0] valve, valve_n;
    logic [N_ZONES-1:0] zone_bit;
    logic [CNT_W-1:0]   dur_arr [N_ZONES];
    logic [CNT_W-1:0]   dur_sel;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero, cnt_load, cnt_clr, cnt_dec;

    function automatic logic [ZW-1:0] rr_pick(input logic [N_ZONES-1:0] req,
                                              input logic [ZW-1:0] ptr);
        logic [ZW-1:0] sel;
        logic          found;
        int unsigned   idx;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N_ZONES; i++) begin
            idx = (32'(ptr) + i) % N_ZONES;
            if (!found && req[idx]) begin
                sel   = ZW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [ZW-1:0] next_zone(input logic [ZW-1:0] z);
        return (int'(z) == N_ZONES - 1) ? '0 : z + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < N_ZONES; k++) begin
            dur_arr[k] = zif.DUR[k*CNT_W +: CNT_W];
        end
    end

    assign dur_sel  = dur_arr[active_zone];
    assign zone_bit = N_ZONES'(1) << active_zone;

    irrig_down_counter #(.CNT_W(CNT_W)) u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (dur_sel),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            active_zone <= '0;
            pending     <= '0;
            valve       <= '0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_n;
            active_zone <= az_n;
            // OR-ing requests after the clear lets a same-cycle request win
            pending     <= (pending & ~pend_clr) | zif.ZONE_REQ;
            valve       <= valve_n;
        end
    end

    always_comb begin
        state_n  = state;
        rr_n     = rr_ptr;
        az_n     = active_zone;
        pend_clr = '0;
        valve_n  = '0;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (zif.EN && (|pending)) begin
                    az_n    = rr_pick(pending, rr_ptr);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (zif.ABORT) begin
                    cnt_clr  = 1'b1;
                    pend_clr = zone_bit;
                    rr_n     = next_zone(active_zone);
                    state_n  = IDLE;
                end else begin
                    cnt_load = 1'b1;
                    if (dur_sel == '0) begin
                        pend_clr = zone_bit;
                        rr_n     = next_zone(active_zone);
                        state_n  = IDLE;
                    end else begin
                        valve_n  = zif.EN ? zone_bit : '0;
                        state_n  = RUN;
                    end
                end
            end
            RUN: begin
                if (zif.ABORT) begin
                    cnt_clr  = 1'b1;
                    pend_clr = zone_bit;
                    rr_n     = next_zone(active_zone);
                    state_n  = IDLE;
                end else begin
                    cnt_dec = zif.TICK && zif.EN && !cnt_zero;
                    if (cnt_dec && (cnt == CNT_W'(1))) begin
                        state_n = DONE;
                    end else begin
                        valve_n = zif.EN ? zone_bit : '0;
                    end
                end
            end
            DONE: begin
                pend_clr = zone_bit;
                rr_n     = next_zone(active_zone);
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign zif.VALVE       = valve;
    assign zif.ACTIVE_ZONE = (state == IDLE) ? '0 : active_zone;
    assign zif.REMAIN      = cnt;
    assign zif.BUSY        = (state != IDLE);
    assign zif.DONE_P      = (state == DONE);
    assign zif.PENDING     = pending;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed self-checking bench for irrigation_zone_scheduler (4 zones, 8-bit timer).
module tb_irrigation_zone_scheduler;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    irrigation_zone_scheduler_if #(.N_ZONES(4), .CNT_W(8)) zif ();

    irrigation_zone_scheduler #(.N_ZONES(4), .CNT_W(8)) dut (
        .CLK   (clk),
        .RESET (reset),
        .zif   (zif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        zif.EN       = 1'b0;
        zif.TICK     = 1'b0;
        zif.ZONE_REQ = '0;
        zif.ABORT    = 1'b0;
        cyc();
        cyc();
        reset  = 1'b0;
        zif.EN = 1'b1;
    endtask

    task automatic test_reset();
        zif.DUR = '0;
        do_reset();
        total++; if (zif.VALVE !== 4'b0000) begin bad++; $display("FAIL reset_valve got=%b exp=0000", zif.VALVE); end
        total++; if (zif.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", zif.BUSY); end
        total++; if (zif.PENDING !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", zif.PENDING); end
        total++; if (zif.REMAIN !== 8'd0) begin bad++; $display("FAIL reset_remain got=%0d exp=0", zif.REMAIN); end
        total++; if (zif.DONE_P !== 1'b0 || zif.ACTIVE_ZONE !== 2'd0) begin bad++; $display("FAIL reset_done_az got=%b/%0d exp=0/0", zif.DONE_P, zif.ACTIVE_ZONE); end
    endtask

    task automatic test_single();
        do_reset();
        zif.DUR      = {8'd2, 8'd2, 8'd3, 8'd2};
        zif.ZONE_REQ = 4'b0010;
        cyc();
        zif.ZONE_REQ = 4'b0000;
        total++; if (zif.PENDING !== 4'b0010 || zif.BUSY !== 1'b0) begin bad++; $display("FAIL single_e0 got=%b/%b exp=0010/0", zif.PENDING, zif.BUSY); end
        cyc();
        total++; if (zif.BUSY !== 1'b1 || zif.ACTIVE_ZONE !== 2'd1 || zif.VALVE !== 4'b0000) begin bad++; $display("FAIL single_grant got=%b/%0d/%b exp=1/1/0000", zif.BUSY, zif.ACTIVE_ZONE, zif.VALVE); end
        zif.TICK = 1'b1;
        cyc();
        zif.TICK = 1'b0;
        total++; if (zif.VALVE !== 4'b0010 || zif.REMAIN !== 8'd3) begin bad++; $display("FAIL single_run got=%b/%0d exp=0010/3", zif.VALVE, zif.REMAIN); end
        zif.TICK = 1'b1; cyc(); zif.TICK = 1'b0;
        cyc();
        total++; if (zif.VALVE !== 4'b0010 || zif.REMAIN !== 8'd2) begin bad++; $display("FAIL single_tick1 got=%b/%0d exp=0010/2", zif.VALVE, zif.REMAIN); end
        zif.TICK = 1'b1; cyc(); zif.TICK = 1'b0;
        total++; if (zif.VALVE !== 4'b0010 || zif.REMAIN !== 8'd1) begin bad++; $display("FAIL single_tick2 got=%b/%0d exp=0010/1", zif.VALVE, zif.REMAIN); end
        zif.TICK = 1'b1; cyc(); zif.TICK = 1'b0;
        total++; if (zif.VALVE !== 4'b0000 || zif.DONE_P !== 1'b1 || zif.REMAIN !== 8'd0 || zif.ACTIVE_ZONE !== 2'd1) begin bad++; $display("FAIL single_done got=%b/%b/%0d/%0d exp=0000/1/0/1", zif.VALVE, zif.DONE_P, zif.REMAIN, zif.ACTIVE_ZONE); end
        cyc();
        total++; if (zif.DONE_P !== 1'b0 || zif.PENDING !== 4'b0000 || zif.BUSY !== 1'b0) begin bad++; $display("FAIL single_idle got=%b/%b/%b exp=0/0000/0", zif.DONE_P, zif.PENDING, zif.BUSY); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [$];
        logic [1:0] exp_order [4];
        bit         rereq;
        bit         finished;
        exp_order = '{2'd0, 2'd1, 2'd3, 2'd0};
        rereq     = 1'b0;
        finished  = 1'b0;
        do_reset();
        zif.DUR      = {8'd2, 8'd2, 8'd2, 8'd2};
        zif.TICK     = 1'b1;
        zif.ZONE_REQ = 4'b1011;
        cyc();
        zif.ZONE_REQ = 4'b0000;
        for (int c = 0; c < 80; c++) begin
            if (c > 0 && !zif.BUSY && zif.PENDING == 4'b0000) begin
                finished = 1'b1;
                break;
            end
            if (zif.DONE_P) order.push_back(zif.ACTIVE_ZONE);
            if (!rereq && zif.VALVE == 4'b0010) begin
                zif.ZONE_REQ = 4'b0001;
                rereq = 1'b1;
            end else begin
                zif.ZONE_REQ = 4'b0000;
            end
            cyc();
        end
        zif.TICK = 1'b0;
        total++; if (!finished) begin bad++; $display("FAIL rr_finish got=timeout exp=idle"); end
        total++; if (order.size() != 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", order.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= order.size()) begin
                bad++; $display("FAIL rr_order[%0d] got=none exp=%0d", i, exp_order[i]);
            end else if (order[i] !== exp_order[i]) begin
                bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_zero_dur();
        do_reset();
        zif.DUR      = {8'd5, 8'd0, 8'd5, 8'd5};
        zif.ZONE_REQ = 4'b0100;
        cyc();
        zif.ZONE_REQ = 4'b0000;
        cyc();
        total++; if (zif.BUSY !== 1'b1 || zif.ACTIVE_ZONE !== 2'd2 || zif.VALVE !== 4'b0000) begin bad++; $display("FAIL zero_grant got=%b/%0d/%b exp=1/2/0000", zif.BUSY, zif.ACTIVE_ZONE, zif.VALVE); end
        cyc();
        total++; if (zif.BUSY !== 1'b0 || zif.PENDING !== 4'b0000 || zif.VALVE !== 4'b0000 || zif.DONE_P !== 1'b0 || zif.REMAIN !== 8'd0) begin bad++; $display("FAIL zero_skip got=%b/%b/%b/%b/%0d exp=0/0000/0000/0/0", zif.BUSY, zif.PENDING, zif.VALVE, zif.DONE_P, zif.REMAIN); end
        // rr_ptr moved past zone 2, so zone 3 must beat zone 0
        zif.ZONE_REQ = 4'b1001;
        cyc();
        zif.ZONE_REQ = 4'b0000;
        cyc();
        total++; if (zif.ACTIVE_ZONE !== 2'd3) begin bad++; $display("FAIL zero_rr got=%0d exp=3", zif.ACTIVE_ZONE); end
    endtask

    task automatic test_pause_abort();
        do_reset();
        zif.DUR      = {8'd2, 8'd2, 8'd2, 8'd8};
        zif.ZONE_REQ = 4'b0001;
        cyc();
        zif.ZONE_REQ = 4'b0000;
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            zif.TICK = 1'b1; cyc(); zif.TICK = 1'b0;
        end
        total++; if (zif.REMAIN !== 8'd5 || zif.VALVE !== 4'b0001) begin bad++; $display("FAIL pause_pre got=%0d/%b exp=5/0001", zif.REMAIN, zif.VALVE); end
        zif.EN   = 1'b0;
        zif.TICK = 1'b1;
        cyc();
        cyc();
        total++; if (zif.VALVE !== 4'b0000 || zif.REMAIN !== 8'd5 || zif.BUSY !== 1'b1) begin bad++; $display("FAIL pause_hold got=%b/%0d/%b exp=0000/5/1", zif.VALVE, zif.REMAIN, zif.BUSY); end
        zif.EN   = 1'b1;
        zif.TICK = 1'b0;
        cyc();
        total++; if (zif.VALVE !== 4'b0001 || zif.REMAIN !== 8'd5) begin bad++; $display("FAIL pause_resume got=%b/%0d exp=0001/5", zif.VALVE, zif.REMAIN); end
        zif.ABORT = 1'b1;
        cyc();
        zif.ABORT = 1'b0;
        total++; if (zif.BUSY !== 1'b0 || zif.VALVE !== 4'b0000 || zif.REMAIN !== 8'd0 || zif.DONE_P !== 1'b0 || zif.PENDING !== 4'b0000) begin bad++; $display("FAIL abort got=%b/%b/%0d/%b/%b exp=0/0000/0/0/0000", zif.BUSY, zif.VALVE, zif.REMAIN, zif.DONE_P, zif.PENDING); end
        cyc();
        total++; if (zif.DONE_P !== 1'b0 || zif.BUSY !== 1'b0) begin bad++; $display("FAIL abort_after got=%b/%b exp=0/0", zif.DONE_P, zif.BUSY); end
    endtask

    task automatic test_collision();
        do_reset();
        zif.DUR      = {8'd2, 8'd2, 8'd2, 8'd1};
        zif.ZONE_REQ = 4'b0001;
        cyc();
        zif.ZONE_REQ = 4'b0000;
        cyc();
        cyc();
        zif.TICK = 1'b1; cyc(); zif.TICK = 1'b0;
        total++; if (zif.DONE_P !== 1'b1 || zif.ACTIVE_ZONE !== 2'd0) begin bad++; $display("FAIL coll_done got=%b/%0d exp=1/0", zif.DONE_P, zif.ACTIVE_ZONE); end
        zif.ZONE_REQ = 4'b0001;
        cyc();
        zif.ZONE_REQ = 4'b0000;
        total++; if (zif.PENDING !== 4'b0001 || zif.BUSY !== 1'b0) begin bad++; $display("FAIL coll_pending got=%b/%b exp=0001/0", zif.PENDING, zif.BUSY); end
        cyc();
        cyc();
        total++; if (zif.VALVE !== 4'b0001 || zif.REMAIN !== 8'd1) begin bad++; $display("FAIL coll_regrant got=%b/%0d exp=0001/1", zif.VALVE, zif.REMAIN); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        zif.DUR      = {8'd4, 8'd2, 8'd2, 8'd2};
        zif.ZONE_REQ = 4'b1000;
        cyc();
        zif.ZONE_REQ = 4'b0010;
        cyc();
        zif.ZONE_REQ = 4'b0000;
        cyc();
        total++; if (zif.VALVE !== 4'b1000 || zif.PENDING !== 4'b1010) begin bad++; $display("FAIL rstrun_pre got=%b/%b exp=1000/1010", zif.VALVE, zif.PENDING); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total++; if (zif.VALVE !== 4'b0000 || zif.PENDING !== 4'b0000 || zif.REMAIN !== 8'd0 || zif.BUSY !== 1'b0) begin bad++; $display("FAIL rstrun got=%b/%b/%0d/%b exp=0000/0000/0/0", zif.VALVE, zif.PENDING, zif.REMAIN, zif.BUSY); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_dur();
        test_pause_abort();
        test_collision();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
